bcd_timer_core: RTL and testbench

Parametrised successor of the minutes/seconds counter and timer state machine in the timer display path. It combines a prescaler, BCD mm:ss time register, preset register and control FSM in one block. It adds count-up (stopwatch) mode with target, auto-reload countdown, and a configurable minute range and tick rate. It takes debounced single-cycle button pulses and feeds BCD digits and state to the VGA painter.

---
 rtl/bcd_timer_core.sv | 154 +++++++++++++++
 tb/tb_bcd_timer_core.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_timer_core.sv
// bcd_timer_core: prescaler, BCD mm:ss time register, preset register and
// control FSM for the timer display path. Supports countdown (optionally
// auto-reloading) and count-up towards a target, fed by single-cycle pulses.
module bcd_timer_core #(
    parameter int TICK_DIV    = 100000000,
    parameter int MAX_MIN     = 99,
    parameter int AUTO_RELOAD = 0
) (
    input  logic        CLK_100MHZ,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic        delete,
    input  logic        incrementSeconds,
    input  logic        incrementMinutes,
    input  logic        mode_up,
    output logic [15:0] time_bcd,
    output logic [2:0]  actualState,
    output logic        running,
    output logic        finish,
    output logic        done
);
    localparam int              PW      = $clog2(TICK_DIV);
    localparam logic [PW-1:0]   PMAX    = PW'(TICK_DIV - 1);
    localparam logic [7:0]      MAX_BCD = {4'(MAX_MIN / 10), 4'(MAX_MIN % 10)};

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RUN   = 3'd1;
    localparam logic [2:0] S_PAUSE = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;

    logic [2:0]    state, n_state;
    logic [15:0]   tm, n_tm;
    logic [15:0]   preset, n_pre;
    logic [PW-1:0] presc, n_presc;
    logic          md, n_md;
    logic          n_fin;

    // seconds +1, 59 wraps to 00 (carry detected by the caller)
    function automatic logic [7:0] sec_inc(input logic [7:0] s);
        if (s == 8'h59)       return 8'h00;
        if (s[3:0] == 4'd9)   return {s[7:4] + 4'd1, 4'd0};
        return {s[7:4], s[3:0] + 4'd1};
    endfunction

    // minutes +1, MAX_MIN wraps to 00
    function automatic logic [7:0] min_inc(input logic [7:0] m);
        if (m == MAX_BCD)     return 8'h00;
        if (m[3:0] == 4'd9)   return {m[7:4] + 4'd1, 4'd0};
        return {m[7:4], m[3:0] + 4'd1};
    endfunction

    // any BCD pair -1, 00 stays 00 (seconds borrow handled by the caller)
    function automatic logic [7:0] pair_dec(input logic [7:0] p);
        if (p == 8'h00)       return 8'h00;
        if (p[3:0] == 4'd0)   return {p[7:4] - 4'd1, 4'd9};
        return {p[7:4], p[3:0] - 4'd1};
    endfunction

    function automatic logic [15:0] tm_inc(input logic [15:0] t);
        return {(t[7:0] == 8'h59) ? min_inc(t[15:8]) : t[15:8], sec_inc(t[7:0])};
    endfunction

    // saturates at 00:00 so a stray tick can never produce illegal digits
    function automatic logic [15:0] tm_dec(input logic [15:0] t);
        if (t == 16'h0000)    return 16'h0000;
        if (t[7:0] == 8'h00)  return {pair_dec(t[15:8]), 8'h59};
        return {t[15:8], pair_dec(t[7:0])};
    endfunction

    logic        tick, expire;
    logic [15:0] target, tm_tick;

    assign tick    = (presc == PMAX);
    assign target  = (preset == 16'h0000) ? {MAX_BCD, 8'h59} : preset;
    assign tm_tick = md ? tm_inc(tm) : tm_dec(tm);
    assign expire  = md ? (tm_tick == target) : (tm_tick == 16'h0000);

    assign time_bcd    = (state == S_IDLE) ? preset : tm;
    assign actualState = state;
    assign running     = (state == S_RUN);
    assign done        = (state == S_DONE);

    // next-state logic; only the highest-priority pulse acts
    always_comb begin
        n_state = state;
        n_tm    = tm;
        n_pre   = preset;
        n_presc = presc;
        n_md    = md;
        n_fin   = 1'b0;
        if (delete) begin
            n_state = S_IDLE;
            n_tm    = 16'h0000;
            n_pre   = 16'h0000;
            n_presc = '0;
        end else begin
            case (state)
                S_IDLE: if (!stop) begin
                    if (start) begin
                        // a countdown from 00:00 would expire immediately, so refuse it
                        if (mode_up || preset != 16'h0000) begin
                            n_state = S_RUN;
                            n_md    = mode_up;
                            n_presc = '0;
                            n_tm    = mode_up ? 16'h0000 : preset;
                        end
                    end else if (incrementMinutes) begin
                        n_pre[15:8] = min_inc(preset[15:8]);
                    end else if (incrementSeconds) begin
                        n_pre[7:0] = sec_inc(preset[7:0]);
                    end
                end
                S_RUN: begin
                    // auto-reload happens in the cycle finish is high, so 00:00 is shown once
                    if (finish && AUTO_RELOAD != 0 && !md) n_tm = preset;
                    if (stop) n_state = S_PAUSE;
                    if (tick) begin
                        n_presc = '0;
                        n_tm    = tm_tick;
                        if (expire) begin
                            n_fin   = 1'b1;
                            n_state = (md || AUTO_RELOAD == 0) ? S_DONE : S_RUN;
                        end
                    end else if (!stop) begin
                        n_presc = presc + 1'b1;
                    end
                end
                S_PAUSE: if (!stop && start) n_state = S_RUN;
                S_DONE:  if (stop || start)  n_state = S_IDLE;
                default: n_state = S_IDLE;
            endcase
        end
    end

    // state registers with asynchronous clear
    always_ff @(posedge CLK_100MHZ or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            tm     <= 16'h0000;
            preset <= 16'h0000;
            presc  <= '0;
            md     <= 1'b0;
            finish <= 1'b0;
        end else begin
            state  <= n_state;
            tm     <= n_tm;
            preset <= n_pre;
            presc  <= n_presc;
            md     <= n_md;
            finish <= n_fin;
        end
    end
endmodule

// File: tb/tb_bcd_timer_core.sv
// Bench for bcd_timer_core: three parameterisations share one stimulus stream
// and are checked every cycle against an integer-seconds reference model,
// plus a directed vector table and hand-written corner sequences.
module tb_bcd_timer_core;
    localparam int N = 3;

    logic clk = 1'b0;
    logic rst, start, stop, del, inc_s, inc_m, mode;
    logic [15:0] t_o   [N];
    logic [2:0]  st_o  [N];
    logic        run_o [N];
    logic        fin_o [N];
    logic        done_o[N];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bcd_timer_core #(.TICK_DIV(4), .MAX_MIN(99), .AUTO_RELOAD(0)) u_a (
        .CLK_100MHZ(clk), .reset(rst), .start(start), .stop(stop), .delete(del),
        .incrementSeconds(inc_s), .incrementMinutes(inc_m), .mode_up(mode),
        .time_bcd(t_o[0]), .actualState(st_o[0]), .running(run_o[0]),
        .finish(fin_o[0]), .done(done_o[0]));
    bcd_timer_core #(.TICK_DIV(2), .MAX_MIN(1), .AUTO_RELOAD(0)) u_b (
        .CLK_100MHZ(clk), .reset(rst), .start(start), .stop(stop), .delete(del),
        .incrementSeconds(inc_s), .incrementMinutes(inc_m), .mode_up(mode),
        .time_bcd(t_o[1]), .actualState(st_o[1]), .running(run_o[1]),
        .finish(fin_o[1]), .done(done_o[1]));
    bcd_timer_core #(.TICK_DIV(3), .MAX_MIN(99), .AUTO_RELOAD(1)) u_c (
        .CLK_100MHZ(clk), .reset(rst), .start(start), .stop(stop), .delete(del),
        .incrementSeconds(inc_s), .incrementMinutes(inc_m), .mode_up(mode),
        .time_bcd(t_o[2]), .actualState(st_o[2]), .running(run_o[2]),
        .finish(fin_o[2]), .done(done_o[2]));

    function automatic int td(int k);
        case (k) 0: return 4; 1: return 2; default: return 3; endcase
    endfunction
    function automatic int mm(int k);
        return (k == 1) ? 1 : 99;
    endfunction
    function automatic bit ar(int k);
        return (k == 2);
    endfunction

    // reference model: times kept as plain seconds, preset as minutes/seconds
    int m_st[N], m_t[N], m_pm[N], m_ps[N], m_pc[N];
    bit m_md[N], m_fin[N];

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_st[k] = 0; m_t[k] = 0; m_pm[k] = 0; m_ps[k] = 0;
            m_pc[k] = 0; m_md[k] = 0; m_fin[k] = 0;
        end
    endtask

    task automatic model_step(int k);
        int pre, nst, tgt;
        bit nfin;
        pre  = m_pm[k] * 60 + m_ps[k];
        nst  = m_st[k];
        nfin = 0;
        if (del) begin
            nst = 0; m_t[k] = 0; m_pm[k] = 0; m_ps[k] = 0; m_pc[k] = 0;
        end else if (m_st[k] == 0) begin
            if (stop) ;
            else if (start) begin
                if (mode || pre != 0) begin
                    nst = 1; m_md[k] = mode; m_pc[k] = 0; m_t[k] = mode ? 0 : pre;
                end
            end else if (inc_m) m_pm[k] = (m_pm[k] == mm(k)) ? 0 : m_pm[k] + 1;
            else if (inc_s) m_ps[k] = (m_ps[k] + 1) % 60;
        end else if (m_st[k] == 1) begin
            if (m_fin[k] && ar(k) && !m_md[k]) m_t[k] = pre;
            if (stop) nst = 2;
            if (m_pc[k] == td(k) - 1) begin
                m_pc[k] = 0;
                if (m_md[k]) begin
                    tgt = (pre == 0) ? mm(k) * 60 + 59 : pre;
                    m_t[k] = m_t[k] + 1;
                    if (m_t[k] == tgt) begin nfin = 1; nst = 3; end
                end else begin
                    if (m_t[k] > 0) m_t[k] = m_t[k] - 1;
                    if (m_t[k] == 0) begin nfin = 1; nst = ar(k) ? 1 : 3; end
                end
            end else if (!stop) m_pc[k] = m_pc[k] + 1;
        end else if (m_st[k] == 2) begin
            if (!stop && start) nst = 1;
        end else begin
            if (stop || start) nst = 0;
        end
        m_st[k]  = nst;
        m_fin[k] = nfin;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else for (int k = 0; k < N; k++) model_step(k);
    end

    function automatic logic [15:0] to_bcd(int s);
        int m, x;
        m = s / 60; x = s % 60;
        return {4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
    endfunction

    task automatic auto_check();
        logic [21:0] got, exp;
        for (int k = 0; k < N; k++) begin
            exp = {(m_st[k] == 0) ? to_bcd(m_pm[k] * 60 + m_ps[k]) : to_bcd(m_t[k]),
                   3'(m_st[k]), m_st[k] == 1, m_fin[k], m_st[k] == 3};
            got = {t_o[k], st_o[k], run_o[k], fin_o[k], done_o[k]};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL model_cmp dut%0d @%0t got t=%h st=%0d r/f/d=%b required t=%h st=%0d r/f/d=%b",
                         k, $time, got[21:6], got[5:3], got[2:0], exp[21:6], exp[5:3], exp[2:0]);
            end
        end
    endtask

    // every wait goes through here: check at the falling edge, drive 2 units later
    task automatic cyc();
        @(negedge clk);
        if (!rst) auto_check();
        #2;
    endtask

    task automatic chk(string nm, int k, logic [15:0] et, logic [2:0] es, logic ef);
        checks++;
        if ({t_o[k], st_o[k], fin_o[k]} !== {et, es, ef}) begin
            errors++;
            $display("FAIL %s dut%0d got t=%h st=%0d fin=%b required t=%h st=%0d fin=%b",
                     nm, k, t_o[k], st_o[k], fin_o[k], et, es, ef);
        end
    endtask

    task automatic clr();
        del = 0; stop = 0; start = 0; inc_m = 0; inc_s = 0;
    endtask

    task automatic pulse_s(int n);
        repeat (n) begin inc_s = 1; cyc(); inc_s = 0; end
    endtask

    typedef struct {
        logic d, sp, sr, im, is, md;
        int n;
        logic [15:0] t;
        logic [2:0] s;
        logic f;
    } vec_t;

    vec_t tbl[32];
    int   ntbl;

    task automatic add(logic d, logic sp, logic sr, logic im, logic is, int n,
                       logic [15:0] t, logic [2:0] s, logic f);
        tbl[ntbl] = '{d, sp, sr, im, is, 1'b0, n, t, s, f};
        ntbl++;
    endtask

    initial begin
        rst = 1; mode = 0; clr();
        ntbl = 0;
        // countdown 00:02 on TICK_DIV=4
        add(1,0,0,0,0, 1, 16'h0000, 0, 0);
        add(0,0,0,0,1, 1, 16'h0001, 0, 0);
        add(0,0,0,0,1, 1, 16'h0002, 0, 0);
        add(0,0,1,0,0, 1, 16'h0002, 1, 0);
        add(0,0,0,0,0, 4, 16'h0001, 1, 0);
        add(0,0,0,0,0, 4, 16'h0000, 3, 1);
        add(0,0,0,0,0, 1, 16'h0000, 3, 0);
        add(0,1,0,0,0, 1, 16'h0002, 0, 0);
        // borrow 01:00 -> 00:59
        add(1,0,0,0,0, 1, 16'h0000, 0, 0);
        add(0,0,0,1,0, 1, 16'h0100, 0, 0);
        add(0,0,1,0,0, 1, 16'h0100, 1, 0);
        add(0,0,0,0,0, 4, 16'h0059, 1, 0);
        // priority
        add(1,0,0,0,0, 1, 16'h0000, 0, 0);
        add(0,0,0,1,1, 1, 16'h0100, 0, 0);
        add(0,1,1,0,0, 1, 16'h0100, 0, 0);
        add(1,0,1,0,0, 1, 16'h0000, 0, 0);
        // pause at prescaler 2, resume, tick exactly 2 edges later
        add(0,0,0,0,1, 1, 16'h0001, 0, 0);
        add(0,0,0,0,1, 1, 16'h0002, 0, 0);
        add(0,0,1,0,0, 1, 16'h0002, 1, 0);
        add(0,0,0,0,0, 2, 16'h0002, 1, 0);
        add(0,1,0,0,0, 1, 16'h0002, 2, 0);
        add(0,0,0,0,0, 10, 16'h0002, 2, 0);
        add(0,0,1,0,0, 1, 16'h0002, 1, 0);
        add(0,0,0,0,0, 1, 16'h0002, 1, 0);
        add(0,0,0,0,0, 1, 16'h0001, 1, 0);
        add(0,1,1,1,1, 1, 16'h0001, 2, 0);

        repeat (2) cyc();
        rst = 0;
        cyc();
        chk("reset_state", 0, 16'h0000, 0, 0);

        for (int i = 0; i < ntbl; i++) begin
            del = tbl[i].d; stop = tbl[i].sp; start = tbl[i].sr;
            inc_m = tbl[i].im; inc_s = tbl[i].is; mode = tbl[i].md;
            cyc(); clr();
            repeat (tbl[i].n - 1) cyc();
            chk($sformatf("vec%0d", i), 0, tbl[i].t, tbl[i].s, tbl[i].f);
        end

        // 60 second increments wrap without touching minutes
        del = 1; cyc(); clr();
        pulse_s(60);
        chk("sec_wrap", 0, 16'h0000, 0, 0);
        pulse_s(59);
        chk("sec_59", 0, 16'h0059, 0, 0);

        // count-up to preset 00:03, TICK_DIV=2
        del = 1; cyc(); clr();
        pulse_s(3);
        mode = 1; start = 1; cyc(); clr();
        chk("up_load", 1, 16'h0000, 1, 0);
        repeat (2) cyc(); chk("up_1", 1, 16'h0001, 1, 0);
        repeat (2) cyc(); chk("up_2", 1, 16'h0002, 1, 0);
        repeat (2) cyc(); chk("up_3", 1, 16'h0003, 3, 1);
        cyc();            chk("up_hold", 1, 16'h0003, 3, 0);
        stop = 1; cyc(); clr();
        chk("up_ack", 1, 16'h0003, 0, 0);

        // count-up with preset 00:00, MAX_MIN=1 stops at 01:59
        del = 1; cyc(); clr();
        start = 1; cyc(); clr();
        repeat (237) cyc();
        chk("up_max_pre", 1, 16'h0158, 1, 0);
        cyc();
        chk("up_max", 1, 16'h0159, 3, 1);
        repeat (5) cyc();
        chk("up_max_hold", 1, 16'h0159, 3, 0);
        mode = 0;

        // auto-reload countdown from 00:01, TICK_DIV=3
        del = 1; cyc(); clr();
        pulse_s(1);
        start = 1; cyc(); clr();
        chk("ar_load", 2, 16'h0001, 1, 0);
        repeat (3) cyc();
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("ar_exp%0d", j), 2, 16'h0000, 1, 1);
            cyc();
            chk($sformatf("ar_rel%0d", j), 2, 16'h0001, 1, 0);
            repeat (2) cyc();
        end

        // asynchronous reset mid-run at 01:23
        del = 1; cyc(); clr();
        inc_m = 1; cyc(); clr();
        pulse_s(23);
        start = 1; cyc(); clr();
        repeat (3) cyc();
        chk("run_0123", 0, 16'h0123, 1, 0);
        rst = 1;
        #1;
        chk("async_rst", 0, 16'h0000, 0, 0);
        cyc();
        rst = 0;

        // randomized stream, model-checked every cycle
        for (int c = 0; c < 20000; c++) begin
            del   = ($urandom_range(0, 199) == 0);
            stop  = ($urandom_range(0, 99) < 3);
            start = ($urandom_range(0, 99) < 6);
            inc_m = ($urandom_range(0, 99) < 5);
            inc_s = ($urandom_range(0, 99) < 12);
            mode  = $urandom_range(0, 1);
            cyc();
        end
        clr();
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
